uart_instruction_receiver: RTL and testbench
============================================

UART_INSTRUCTION_RECEIVER -- requirements
Module: uart_instruction_receiver

Interface
REQ-001 SHALL provide parameter DATA_W, default 15, instruction width in data bits.
REQ-002 SHALL provide parameter CLKS_PER_BIT, default 434, clocks per bit (50 MHz / 115200 baud).
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4, power of two >= 2, received-instruction buffer depth.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx  input  1  serial line; idle high, start bit low, LSB first, stop bit high.
REQ-007 instruction_out  output  DATA_W  head-of-FIFO instruction; valid while instruction_valid=1.
REQ-008 instruction_valid  output  1  FIFO non-empty.
REQ-009 instruction_accept  input  1  consumer pops the head when high with instruction_valid.
REQ-010 frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overflow  output  1  one-cycle pulse: completed frame dropped because FIFO was full.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored instructions.

Function
REQ-013 rx SHALL pass through a 2-flop synchroniser; all sampling uses the synchronised value.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH (plus PARITY per REQ-031).
REQ-015 IDLE -> START when synchronised rx is 0; bit counter cleared.
REQ-016 START: after CLKS_PER_BIT/2 clocks, resample; 0 -> DATA, 1 -> IDLE (glitch, no error, no pulse).
REQ-017 DATA: sample every CLKS_PER_BIT clocks (mid-bit), shift in LSB first; after DATA_W samples -> STOP.
REQ-018 STOP: sample after CLKS_PER_BIT clocks; 1 -> push frame, IDLE; 0 -> frame_error pulse, discard, WAIT_HIGH.
REQ-019 WAIT_HIGH -> IDLE on first synchronised rx=1; no new start accepted before.
REQ-020 Push SHALL occur in the cycle after the stop-bit sample; instruction_valid rises the following cycle when FIFO was empty.
REQ-021 FIFO SHALL be first-word-fall-through; pop when instruction_valid && instruction_accept.
REQ-022 Push while full without pop: frame dropped, overflow pulse, contents unchanged.
REQ-023 Push and pop in same cycle when full: both succeed, no overflow, count unchanged.
REQ-024 Pop with FIFO empty SHALL be ignored; count never underflows.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Reset
REQ-026 Reset SHALL force: FSM IDLE, counters 0, synchroniser 1s, FIFO empty.
REQ-027 Reset values: instruction_out 0, instruction_valid 0, frame_error 0, overflow 0, fifo_count 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; next complete frame after release received normally.

Configuration
REQ-029 Macro UART_RX_PARITY_EN SHALL select parity support.
REQ-030 Undefined: no parity bit, no parity_error port; frame = start + DATA_W + stop.
REQ-031 Defined: PARITY state between DATA and STOP samples one even-parity bit; output port parity_error (1 bit, reset 0) added.
REQ-032 Defined: parity mismatch SHALL pulse parity_error one cycle after the stop-bit sample, drop frame, no push; frame_error takes precedence if stop also low.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state enum and constant CLKS_PER_BIT_50M_115200 = 434.
REQ-034 FIFO SHALL be sub-module uart_rx_fifo (params WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-035 Send 15'h5555 -> instruction_valid within 2 clocks of stop mid-bit, instruction_out=15'h5555, accept pops, count 0.
REQ-036 rx low 100 ns then high -> no valid, no frame_error, FSM returns IDLE.
REQ-037 Frame 15'h1234 with stop bit 0 -> one frame_error pulse, count stays 0; next valid frame 15'h0F0F received.
REQ-038 Five frames 1..5 with accept low -> count 4, overflow pulse on fifth; drain yields 1,2,3,4.
REQ-039 Reset asserted mid-DATA -> outputs at reset values; subsequent 15'h7FFF received correctly.
REQ-040 With UART_RX_PARITY_EN, frame 15'h0001 with parity bit 0 -> parity_error pulse, no push; correct parity 1 -> received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART instruction receiver.
// UART_RX_PARITY_EN selects the even-parity frame format.
package uart_pkg;

   localparam int CLKS_PER_BIT_50M_115200 = 434;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through buffer for received instructions.
// DEPTH must be a power of two so the pointers wrap on their own.
module uart_rx_fifo #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW  = $clog2(DEPTH);
   localparam int FCW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [FCW-1:0]   count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == FCW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   // A pop frees the slot, so a push into a full buffer can still land.
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + FCW'(push_ok) - FCW'(pop_ok);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_instruction_receiver.sv
// Serial instruction receiver: sync, framing FSM, FWFT buffer.
// UART_RX_PARITY_EN adds an even-parity bit and parity_error.
module uart_instruction_receiver
   import uart_pkg::*;
#(
   parameter int DATA_W       = 15,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_50M_115200,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx,
   output logic [DATA_W-1:0]             instruction_out,
   output logic                          instruction_valid,
   input  logic                          instruction_accept,
   output logic                          frame_error,
`ifdef UART_RX_PARITY_EN
   output logic                          parity_error,
`endif
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   logic [1:0]        sync_q;
   logic              rx_s;
   rx_state_e         state_q, state_d;
   logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              push_q, push_d;
   logic              ferr_q, ferr_d;
   logic              tick_half, tick_full;
   logic              full, empty, pop;
`ifdef UART_RX_PARITY_EN
   logic              par_q, par_d;
   logic              perr_q, perr_d;
`endif

   assign rx_s      = sync_q[1];
   assign tick_half = (clk_cnt_q == HALF_M1);
   assign tick_full = (clk_cnt_q == FULL_M1);

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      push_d    = 1'b0;
      ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d     = par_q;
      perr_d    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (tick_half) begin
               clk_cnt_d = '0;
               state_d   = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick_full) begin
               clk_cnt_d = '0;
               shift_d   = {rx_s, shift_q[DATA_W-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
         PARITY: begin
            if (tick_full) begin
               clk_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
               par_d     = rx_s;
`endif
               state_d   = STOP;
            end
         end
         STOP: begin
            if (tick_full) begin
               clk_cnt_d = '0;
               if (rx_s) begin
                  state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_q != ^shift_q) perr_d = 1'b1;
                  else                   push_d = 1'b1;
`else
                  push_d  = 1'b1;
`endif
               end else begin
                  // Bad stop bit: wait for the line to recover first.
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            clk_cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            clk_cnt_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q    <= 2'b11;
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         push_q    <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         sync_q    <= {sync_q[0], rx};
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         push_q    <= push_d;
         ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q     <= par_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign instruction_valid = !empty;
   assign pop               = instruction_valid && instruction_accept;
   assign overflow          = push_q && full && !pop;
   assign frame_error       = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_error      = perr_q;
`endif

   uart_rx_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_q),
      .wdata_i (shift_q),
      .pop_i   (pop),
      .rdata_o (instruction_out),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_count)
   );

endmodule

// File: tb/tb_uart_instruction_receiver.sv
// Directed bench for uart_instruction_receiver.
// Define UART_RX_PARITY_EN to also exercise the parity frame.
module tb_uart_instruction_receiver;
   import uart_pkg::*;

   localparam int DATA_W = 15;
   localparam int CPB    = 20;
   localparam int H      = CPB / 2;
   localparam int DEPTH  = 4;
   localparam int LAT    = H + 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              rx;
   logic [DATA_W-1:0] instruction_out;
   logic              instruction_valid;
   logic              instruction_accept;
   logic              frame_error;
   logic              overflow;
   logic [2:0]        fifo_count;
`ifdef UART_RX_PARITY_EN
   logic              parity_error;
   int                pe_n = 0;
`endif

   int n_vec = 0;
   int n_err = 0;
   int fe_n  = 0;
   int ov_n  = 0;
   int snap;
   int lat;

   uart_instruction_receiver #(
      .DATA_W       (DATA_W),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk                (clk),
      .reset              (rst),
      .rx                 (rx),
      .instruction_out    (instruction_out),
      .instruction_valid  (instruction_valid),
      .instruction_accept (instruction_accept),
      .frame_error        (frame_error),
`ifdef UART_RX_PARITY_EN
      .parity_error       (parity_error),
`endif
      .overflow           (overflow),
      .fifo_count         (fifo_count)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (frame_error) fe_n++;
      if (overflow)    ov_n++;
`ifdef UART_RX_PARITY_EN
      if (parity_error) pe_n++;
`endif
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop,
                             input logic par, input bit pop_on_push,
                             output int l);
      l  = -1;
      rx = 1'b0;
      cyc(CPB);
      for (int i = 0; i < DATA_W; i++) begin
         rx = d[i];
         cyc(CPB);
      end
`ifdef UART_RX_PARITY_EN
      rx = par;
      cyc(CPB);
`else
      if (par) rx = 1'b0;
`endif
      rx = stop;
      for (int j = 1; j <= CPB; j++) begin
         @(posedge clk);
         #1;
         if (pop_on_push && j == H + 3) instruction_accept = 1'b1;
         if (pop_on_push && j == H + 4) instruction_accept = 1'b0;
         if (l < 0 && instruction_valid) l = j;
      end
      rx = 1'b1;
      cyc(4);
   endtask

   task automatic pop_one(input string tag, input logic [DATA_W-1:0] exp);
      check({tag, "_valid"}, 32'(instruction_valid), 32'd1);
      check({tag, "_data"}, 32'(instruction_out), 32'(exp));
      instruction_accept = 1'b1;
      cyc(1);
      instruction_accept = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      instruction_accept = 1'b0;
      cyc(3);
      check("rst_out", 32'(instruction_out), 32'h0);
      check("rst_valid", 32'(instruction_valid), 32'h0);
      check("rst_ferr", 32'(frame_error), 32'h0);
      check("rst_ovf", 32'(overflow), 32'h0);
      check("rst_cnt", 32'(fifo_count), 32'h0);
      rst = 1'b0;
      cyc(5);

      send_frame(15'h5555, 1'b1, 1'b0, 1'b0, lat);
      check("5555_lat", 32'(lat), 32'(LAT));
      check("5555_cnt", 32'(fifo_count), 32'd1);
      pop_one("5555", 15'h5555);
      check("5555_cnt0", 32'(fifo_count), 32'd0);
      check("5555_empty", 32'(instruction_valid), 32'd0);

      snap = fe_n;
      rx = 1'b0;
      cyc(5);
      rx = 1'b1;
      cyc(30);
      check("glitch_valid", 32'(instruction_valid), 32'd0);
      check("glitch_ferr", 32'(fe_n - snap), 32'd0);
      check("glitch_idle", 32'(dut.state_q), 32'(IDLE));

      snap = fe_n;
      send_frame(15'h1234, 1'b0, 1'b0, 1'b0, lat);
      check("ferr_pulse", 32'(fe_n - snap), 32'd1);
      check("ferr_cnt", 32'(fifo_count), 32'd0);
      send_frame(15'h0F0F, 1'b1, 1'b0, 1'b0, lat);
      check("0f0f_lat", 32'(lat), 32'(LAT));
      pop_one("0f0f", 15'h0F0F);

      snap = ov_n;
      for (int k = 1; k <= 4; k++) send_frame(15'(k), 1'b1, 1'b0, 1'b0, lat);
      check("fill_cnt", 32'(fifo_count), 32'd4);
      check("fill_ovf", 32'(ov_n - snap), 32'd0);
      send_frame(15'd5, 1'b1, 1'b0, 1'b0, lat);
      check("ovf_pulse", 32'(ov_n - snap), 32'd1);
      check("ovf_cnt", 32'(fifo_count), 32'd4);
      check("ovf_head", 32'(instruction_out), 32'd1);
      for (int k = 1; k <= 4; k++) pop_one("drain", 15'(k));
      check("drain_cnt", 32'(fifo_count), 32'd0);

      for (int k = 1; k <= 4; k++) send_frame(15'(k), 1'b1, 1'b0, 1'b0, lat);
      snap = ov_n;
      send_frame(15'd6, 1'b1, 1'b0, 1'b1, lat);
      check("pp_ovf", 32'(ov_n - snap), 32'd0);
      check("pp_cnt", 32'(fifo_count), 32'd4);
      pop_one("pp", 15'd2);
      pop_one("pp", 15'd3);
      pop_one("pp", 15'd4);
      pop_one("pp", 15'd6);
      instruction_accept = 1'b1;
      cyc(2);
      instruction_accept = 1'b0;
      check("under_cnt", 32'(fifo_count), 32'd0);
      check("under_valid", 32'(instruction_valid), 32'd0);

      send_frame(15'h0ABC, 1'b1, 1'b0, 1'b0, lat);
      check("pre_rst_cnt", 32'(fifo_count), 32'd1);
      rx = 1'b0;
      cyc(CPB);
      rx = 1'b1;
      cyc(3 * CPB);
      rst = 1'b1;
      cyc(2);
      check("mid_out", 32'(instruction_out), 32'h0);
      check("mid_valid", 32'(instruction_valid), 32'h0);
      check("mid_ferr", 32'(frame_error), 32'h0);
      check("mid_ovf", 32'(overflow), 32'h0);
      check("mid_cnt", 32'(fifo_count), 32'h0);
      rst = 1'b0;
      cyc(10);
      check("post_rst_cnt", 32'(fifo_count), 32'd0);
      send_frame(15'h7FFF, 1'b1, 1'b0, 1'b0, lat);
      check("7fff_lat", 32'(lat), 32'(LAT));
      pop_one("7fff", 15'h7FFF);

`ifdef UART_RX_PARITY_EN
      snap = pe_n;
      send_frame(15'h0001, 1'b1, 1'b0, 1'b0, lat);
      check("par_pulse", 32'(pe_n - snap), 32'd1);
      check("par_cnt", 32'(fifo_count), 32'd0);
      send_frame(15'h0001, 1'b1, 1'b1, 1'b0, lat);
      check("par_ok_pulse", 32'(pe_n - snap), 32'd1);
      pop_one("par_ok", 15'h0001);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
